// File: rtl/delta_scan_ctrl_pkg.sv
// Shared constants and FSM state encoding for the delta-encoded channel scanner.
package delta_scan_ctrl_pkg;

    localparam int P_CH_NUM     = 96;
    localparam int P_CH_BIT     = 7;
    localparam int P_RATE_BIT   = 4;
    localparam int P_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/delta_scan_ctrl_event_fifo.sv
// Small synchronous event FIFO; head word is visible combinationally while not empty.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/delta_scan_ctrl.sv
// Channel scanner: calibrates per-channel baseline rates, then emits
// delta-encoded events for channels whose binned rate differs from baseline.
module delta_scan_ctrl
    import delta_scan_ctrl_pkg::*;
#(
    parameter int CH_NUM     = P_CH_NUM,
    parameter int CH_BIT     = P_CH_BIT,
    parameter int RATE_BIT   = P_RATE_BIT,
    parameter int FIFO_DEPTH = P_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                cal_req,
    input  logic                hist_done,
    input  logic                bin_valid,
    input  logic [RATE_BIT-1:0] spike_rate,
    input  logic [RATE_BIT-1:0] max_rate,
    output logic [CH_BIT-1:0]   channel,
    output logic                ram_we,
    output logic                cal_mode,
    output logic                cal_done,
    output logic                frame_start,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [CH_BIT-1:0]   ev_delta,
    output logic [RATE_BIT-1:0] ev_rate,
    output logic                overflow
);
    localparam logic [CH_BIT-1:0] LP_CH_LAST  = CH_BIT'(CH_NUM - 1);
    localparam logic [CH_BIT:0]   LP_CH_NUM_X = (CH_BIT + 1)'(CH_NUM);

    scan_state_t                  r_state;
    scan_state_t                  w_state_next;
    logic [CH_BIT-1:0]            r_channel;
    logic [CH_BIT-1:0]            w_channel_next;
    logic [CH_BIT-1:0]            r_last_channel;
    logic [CH_BIT-1:0]            w_last_eff;
    logic [CH_BIT-1:0]            w_delta;
    logic                         r_overflow;
    logic                         r_cal_done;
    logic                         w_cal_done_set;
    logic                         w_ram_we;
    logic                         w_frame_start;
    logic                         w_event;
    logic                         w_flush;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [CH_BIT+RATE_BIT-1:0]   w_fifo_dout;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_channel_next = r_channel;
        w_ram_we       = 1'b0;
        w_cal_done_set = 1'b0;
        w_frame_start  = 1'b0;
        w_event        = 1'b0;
        w_flush        = 1'b0;
        if (cal_req) begin
            w_state_next   = ST_CAL;
            w_channel_next = '0;
            w_flush        = 1'b1;
        end else begin
            case (r_state)
                ST_CAL: begin
                    w_ram_we = hist_done;
                    if (hist_done) begin
                        if (r_channel == LP_CH_LAST) begin
                            w_state_next   = ST_RUN;
                            w_channel_next = '0;
                            w_cal_done_set = 1'b1;
                        end else begin
                            w_channel_next = r_channel + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bin_valid) begin
                        w_frame_start  = (r_channel == '0);
                        w_event        = (spike_rate != max_rate);
                        w_channel_next = (r_channel == LP_CH_LAST) ? '0 : r_channel + 1'b1;
                    end
                end
                ST_IDLE: ;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // The frame restart of last_channel must be visible to the delta in the same cycle.
    always_comb begin
        w_last_eff = w_frame_start ? LP_CH_LAST : r_last_channel;
        if (r_channel > w_last_eff)
            w_delta = CH_BIT'({1'b0, r_channel} - {1'b0, w_last_eff});
        else
            w_delta = CH_BIT'({1'b0, r_channel} + LP_CH_NUM_X - {1'b0, w_last_eff});
    end

    assign w_pop  = !w_fifo_empty && ev_ready;
    assign w_push = w_event && (!w_fifo_full || w_pop);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_channel      <= '0;
            r_last_channel <= LP_CH_LAST;
            r_overflow     <= 1'b0;
            r_cal_done     <= 1'b0;
        end else begin
            r_channel  <= w_channel_next;
            r_cal_done <= w_cal_done_set;
            if (cal_req) begin
                r_last_channel <= LP_CH_LAST;
                r_overflow     <= 1'b0;
            end else begin
                if (w_push)
                    r_last_channel <= r_channel;
                else if (w_frame_start)
                    r_last_channel <= LP_CH_LAST;
                if (w_event && w_fifo_full && !w_pop)
                    r_overflow <= 1'b1;
            end
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CH_BIT + RATE_BIT)
    ) u_event_fifo (
        .clk     (clk),
        .RST     (RST),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  ({w_delta, spike_rate}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign channel     = r_channel;
    assign ram_we      = w_ram_we;
    assign cal_mode    = (r_state == ST_CAL);
    assign cal_done    = r_cal_done;
    assign frame_start = w_frame_start;
    assign ev_valid    = !w_fifo_empty;
    assign ev_delta    = w_fifo_dout[CH_BIT+RATE_BIT-1:RATE_BIT];
    assign ev_rate     = w_fifo_dout[RATE_BIT-1:0];
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_delta_scan_ctrl.sv
// Directed bench for delta_scan_ctrl: calibration, delta encoding across frames,
// overflow, cal_req flush and mid-run reset, with hand-computed expectations.
module tb_delta_scan_ctrl;

    logic       clk;
    logic       RST;
    logic       cal_req;
    logic       hist_done;
    logic       bin_valid;
    logic [3:0] spike_rate;
    logic [3:0] max_rate;
    logic [6:0] channel;
    logic       ram_we;
    logic       cal_mode;
    logic       cal_done;
    logic       frame_start;
    logic       ev_valid;
    logic       ev_ready;
    logic [6:0] ev_delta;
    logic [3:0] ev_rate;
    logic       overflow;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_ch = 0;

    delta_scan_ctrl dut (
        .clk         (clk),
        .RST         (RST),
        .cal_req     (cal_req),
        .hist_done   (hist_done),
        .bin_valid   (bin_valid),
        .spike_rate  (spike_rate),
        .max_rate    (max_rate),
        .channel     (channel),
        .ram_we      (ram_we),
        .cal_mode    (cal_mode),
        .cal_done    (cal_done),
        .frame_start (frame_start),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_delta    (ev_delta),
        .ev_rate     (ev_rate),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic calibrate;
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        chk("cal_mode_on", cal_mode, 1);
        chk("cal_ch0", channel, 0);
        for (int ch = 0; ch < 96; ch++) begin
            hist_done = 1'b1;
            #1;
            chk("ram_we", ram_we, 1);
            chk("cal_addr", channel, ch);
            tick();
        end
        hist_done = 1'b0;
        #1;
        chk("cal_done_pulse", cal_done, 1);
        chk("cal_mode_off", cal_mode, 0);
        chk("run_ch0", channel, 0);
        chk("ram_we_idle", ram_we, 0);
        tick();
        chk("cal_done_clear", cal_done, 0);
        exp_ch = 0;
        $display("calibration complete");
    endtask

    task automatic bin(input logic [3:0] rate, input logic rdy);
        bin_valid  = 1'b1;
        spike_rate = rate;
        ev_ready   = rdy;
        #1;
        chk("bin_channel", channel, exp_ch);
        chk("frame_start", frame_start, exp_ch == 0);
        tick();
        bin_valid = 1'b0;
        ev_ready  = 1'b0;
        exp_ch    = (exp_ch == 95) ? 0 : exp_ch + 1;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 96 && exp_ch != target; n++) bin(4'd3, 1'b0);
    endtask

    task automatic pop_chk(input int delta, input int rate);
        chk("pop_valid", ev_valid, 1);
        chk("ev_delta", ev_delta, delta);
        chk("ev_rate", ev_rate, rate);
        $display("pop delta=%0d rate=%0d", ev_delta, ev_rate);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b0; cal_req = 1'b0; hist_done = 1'b0; bin_valid = 1'b0;
        spike_rate = 4'd0; max_rate = 4'd3; ev_ready = 1'b0;
        #2;
        chk("rst_channel", channel, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_cal_mode", cal_mode, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_overflow", overflow, 0);
        tick();
        RST = 1'b1;
        tick();

        calibrate();

        // Events at channels 0, 5, 95 of one frame.
        chk("ev_valid_empty", ev_valid, 0);
        bin(4'd5, 1'b0);
        chk("ev_valid_latency", ev_valid, 1);
        run_to(5);
        bin(4'd7, 1'b0);
        run_to(95);
        bin(4'd9, 1'b0);
        pop_chk(1, 5);
        pop_chk(5, 7);
        pop_chk(90, 9);
        chk("drained", ev_valid, 0);

        // Channel 95, then channel 2 of the following frame.
        run_to(95);
        bin(4'd4, 1'b0);
        run_to(2);
        bin(4'd6, 1'b0);
        pop_chk(96, 4);
        pop_chk(3, 6);
        chk("drained2", ev_valid, 0);

        // Five back-to-back events at channels 3..7 with no consumer.
        for (int k = 0; k < 4; k++) bin(4'd8, 1'b0);
        chk("ovf_before", overflow, 0);
        bin(4'd8, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("head_held", ev_delta, 1);
        // Channel 8: push and pop together while full; delta spans dropped channel 7.
        bin(4'd8, 1'b1);
        chk("ovf_sticky", overflow, 1);
        pop_chk(1, 8);
        pop_chk(1, 8);
        pop_chk(1, 8);
        pop_chk(2, 8);
        chk("drained3", ev_valid, 0);

        // cal_req collides with an event while the FIFO holds one entry.
        bin(4'd1, 1'b0);
        chk("ev_valid_pre_cal", ev_valid, 1);
        bin_valid  = 1'b1;
        spike_rate = 4'd1;
        cal_req    = 1'b1;
        tick();
        bin_valid  = 1'b0;
        cal_req    = 1'b0;
        chk("flush_ev_valid", ev_valid, 0);
        chk("flush_cal_mode", cal_mode, 1);
        chk("flush_channel", channel, 0);
        chk("flush_overflow", overflow, 0);
        tick();
        chk("flush_no_push", ev_valid, 0);

        // Fill and overflow again, then reset mid-run.
        calibrate();
        for (int k = 0; k < 5; k++) bin(4'd2, 1'b0);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_valid", ev_valid, 1);
        bin_valid  = 1'b1;
        spike_rate = 4'd9;
        RST        = 1'b0;
        #2;
        chk("arst_channel", channel, 0);
        chk("arst_ram_we", ram_we, 0);
        chk("arst_cal_mode", cal_mode, 0);
        chk("arst_cal_done", cal_done, 0);
        chk("arst_frame_start", frame_start, 0);
        chk("arst_ev_valid", ev_valid, 0);
        chk("arst_overflow", overflow, 0);
        tick();
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_channel", channel, 0);
            chk("idle_ev_valid", ev_valid, 0);
            chk("idle_frame_start", frame_start, 0);
            chk("idle_cal_mode", cal_mode, 0);
            chk("idle_overflow", overflow, 0);
        end
        bin_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
